// File: rtl/commit_rat_mp_if.sv
// commit_rat_mp_if
//   Groups the buses around the committed register alias table:
//   - retire bus from the ROB commit stage (flush, retire_valid, rd_arch_commit,
//     rd_phy_new_commit)
//   - displaced-tag return to the free list (free_valid, free_phy)
//   - committed map snapshot (back_rat) and busy indication
//   - restore stream to the rename-stage RAT (restore_valid, restore_beat,
//     restore_data, restore_ready, restore_done)
//   Modports:
//   - slave  : the table itself (consumes retires, produces frees/restore)
//   - master : the surrounding pipeline (or a testbench)
interface commit_rat_mp_if #(
  parameter int ARCH_REGS     = 32,
  parameter int PHY_WIDTH     = 6,
  parameter int COMMIT_WIDTH  = 2,
  parameter int RESTORE_LANES = 8
) ();
  localparam int AW     = $clog2(ARCH_REGS);
  localparam int NBEATS = ARCH_REGS / RESTORE_LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  logic                               flush;
  logic [COMMIT_WIDTH-1:0]            retire_valid;
  logic [COMMIT_WIDTH*AW-1:0]         rd_arch_commit;
  logic [COMMIT_WIDTH*PHY_WIDTH-1:0]  rd_phy_new_commit;
  logic [COMMIT_WIDTH-1:0]            free_valid;
  logic [COMMIT_WIDTH*PHY_WIDTH-1:0]  free_phy;
  logic [ARCH_REGS*PHY_WIDTH-1:0]     back_rat;
  logic                               restore_valid;
  logic [BW-1:0]                      restore_beat;
  logic [RESTORE_LANES*PHY_WIDTH-1:0] restore_data;
  logic                               restore_ready;
  logic                               restore_done;
  logic                               busy;

  modport slave (
    input  flush, retire_valid, rd_arch_commit, rd_phy_new_commit, restore_ready,
    output free_valid, free_phy, back_rat, restore_valid, restore_beat,
           restore_data, restore_done, busy
  );

  modport master (
    output flush, retire_valid, rd_arch_commit, rd_phy_new_commit, restore_ready,
    input  free_valid, free_phy, back_rat, restore_valid, restore_beat,
           restore_data, restore_done, busy
  );
endinterface

// File: rtl/commit_rat_mp.sv
// commit_rat_mp
//   Multi-port retirement (committed) register alias table. Up to COMMIT_WIDTH
//   in-order retirements per cycle update the arch->phys map; each retirement
//   returns the tag it displaces to the free list one cycle later. A flush
//   streams the committed map back to the front RAT in RESTORE_LANES-entry
//   beats over a valid/ready handshake, followed by a one-cycle restore_done.
// Ports:
//   clk  - clock
//   rst  - synchronous, active-high reset (map returns to identity)
//   bus  - commit_rat_mp_if.slave: retire bus, free-list return, back_rat,
//          restore stream and busy
// Configuration:
//   COMMIT_RAT_DUMP_EN - when defined, the table is printed on every falling
//   clock edge and after every accepted restore beat (simulation only).
module commit_rat_mp #(
  parameter int ARCH_REGS     = 32,
  parameter int PHY_WIDTH     = 6,
  parameter int COMMIT_WIDTH  = 2,
  parameter int RESTORE_LANES = 8,
  parameter int HARDWIRE_X0   = 1
) (
  input logic clk,
  input logic rst,
  commit_rat_mp_if.slave bus
);
  localparam int AW     = $clog2(ARCH_REGS);
  localparam int NBEATS = ARCH_REGS / RESTORE_LANES;
  localparam int BW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESTORE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t                            state_q, state_d;
  logic [BW-1:0]                     beat_q, beat_d;
  logic [PHY_WIDTH-1:0]              rat_q [ARCH_REGS];
  logic [PHY_WIDTH-1:0]              rat_n [ARCH_REGS];
  logic [AW-1:0]                     arch_k;
  logic [COMMIT_WIDTH-1:0]           free_valid_d, free_valid_p1;
  logic [COMMIT_WIDTH*PHY_WIDTH-1:0] free_phy_d, free_phy_p1;

  // Retire ports are applied to a working copy in port order, so a younger
  // port to the same arch reg sees (and displaces) the older port's new tag,
  // and the last writer wins. Nothing retires while busy or during a flush.
  always_comb begin
    rat_n        = rat_q;
    free_valid_d = '0;
    free_phy_d   = '0;
    arch_k       = '0;
    if (state_q == IDLE && !bus.flush) begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        arch_k = bus.rd_arch_commit[k*AW +: AW];
        if (bus.retire_valid[k] && !(HARDWIRE_X0 != 0 && arch_k == '0)) begin
          free_valid_d[k]                       = 1'b1;
          free_phy_d[k*PHY_WIDTH +: PHY_WIDTH]  = rat_n[arch_k];
          rat_n[arch_k] = bus.rd_phy_new_commit[k*PHY_WIDTH +: PHY_WIDTH];
        end
      end
    end
  end

  // A flush in any state (re)starts the restore at beat 0.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (bus.flush) begin
          state_d = RESTORE;
          beat_d  = '0;
        end
      end
      RESTORE: begin
        if (bus.flush) begin
          beat_d = '0;
        end else if (bus.restore_ready) begin
          if (beat_q == BW'(NBEATS - 1)) begin
            state_d = DONE;
            beat_d  = '0;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      DONE: begin
        state_d = bus.flush ? RESTORE : IDLE;
        beat_d  = '0;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // ---- stage p1: table, FSM and free-list return registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      beat_q        <= '0;
      free_valid_p1 <= '0;
      free_phy_p1   <= '0;
      for (int i = 0; i < ARCH_REGS; i++) begin
        rat_q[i] <= PHY_WIDTH'(i);
      end
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      free_valid_p1 <= free_valid_d;
      free_phy_p1   <= free_phy_d;
      rat_q         <= rat_n;
    end
  end

  assign bus.free_valid    = free_valid_p1;
  assign bus.free_phy      = free_phy_p1;
  assign bus.busy          = (state_q != IDLE);
  assign bus.restore_valid = (state_q == RESTORE);
  assign bus.restore_beat  = beat_q;
  // A flush arriving in DONE aborts the completion, so the pulse is withheld.
  assign bus.restore_done  = (state_q == DONE) && !bus.flush;

  for (genvar i = 0; i < ARCH_REGS; i++) begin : g_back
    assign bus.back_rat[i*PHY_WIDTH +: PHY_WIDTH] = rat_q[i];
  end

  // The table is frozen outside IDLE, so the beat's data stays stable while
  // ready is held low without needing a holding register.
  for (genvar l = 0; l < RESTORE_LANES; l++) begin : g_lane
    logic [AW-1:0] lane_idx;
    assign lane_idx = AW'(int'(beat_q) * RESTORE_LANES + l);
    assign bus.restore_data[l*PHY_WIDTH +: PHY_WIDTH] = rat_q[lane_idx];
  end

`ifdef COMMIT_RAT_DUMP_EN
  task automatic dump_table();
    for (int i = 0; i < ARCH_REGS; i++) begin
      $display("%2d %3d", i, rat_q[i]);
    end
  endtask

  always @(negedge clk) begin
    dump_table();
  end

  always @(posedge clk) begin
    if (!rst && bus.restore_valid && bus.restore_ready) begin
      dump_table();
    end
  end
`endif
endmodule
